// File: rtl/pkt_responder.sv
// pkt_responder: length-prefixed packet sink that checks framing, sums payload and queues {status, sum} responses
// Ports: clk/rst_n (async active-low); in_valid/in_ready/in_data/in_last byte stream in;
//        resp_valid/resp_ready/resp_data response FIFO out; pkt_cnt/err_cnt saturating stats,
//        built only when PKT_RESP_STATS_EN is defined (tied to 0 otherwise).
module pkt_responder #(
  parameter int RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [8:0]  pkt_cnt,
  output logic [8:0]  err_cnt
);
  localparam int AW = $clog2(RESP_DEPTH);
  typedef enum logic [1:0] {HDR, PAY, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [8:0] remaining, remaining_nx, rem_dec;
  logic [7:0] sum, sum_nx, status, status_nx;
  logic [15:0] mem [RESP_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, empty, push, pop, in_fire;
  assign in_fire = in_valid && in_ready;
  assign rem_dec = remaining - 9'd1;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push = (state == DONE) && !full;
  assign pop = resp_valid && resp_ready;
  assign in_ready = state != DONE;
  assign resp_valid = !empty;
  assign resp_data = empty ? 16'h0000 : mem[rd_ptr[AW-1:0]];
  always_comb begin
    state_nx = state;
    remaining_nx = remaining;
    sum_nx = sum;
    status_nx = status;
    case (state)
      HDR: if (in_fire) begin
        // header 0 encodes a 256-byte payload, which the 9th bit carries
        remaining_nx = {in_data == 8'd0, in_data};
        sum_nx = 8'd0;
        status_nx = in_last ? 8'h01 : 8'h00;
        state_nx = in_last ? DONE : PAY;
      end
      PAY: if (in_fire) begin
        remaining_nx = rem_dec;
        sum_nx = sum + in_data;
        status_nx = (in_last && rem_dec != 9'd0) ? 8'h01 : (!in_last && rem_dec == 9'd0) ? 8'h02 : 8'h00;
        state_nx = in_last ? DONE : (rem_dec == 9'd0) ? DRAIN : PAY;
      end
      DRAIN: state_nx = (in_fire && in_last) ? DONE : DRAIN;
      DONE: state_nx = full ? DONE : HDR;
      default: state_nx = HDR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HDR;
      remaining <= 9'd0;
      sum <= 8'd0;
      status <= 8'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_nx;
      remaining <= remaining_nx;
      sum <= sum_nx;
      status <= status_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  // storage needs no reset: resp_data is masked while the FIFO is empty
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {status, sum};
`ifdef PKT_RESP_STATS_EN
  logic [8:0] pkt_q, err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q <= 9'd0;
      err_q <= 9'd0;
    end else if (push) begin
      if (pkt_q != 9'h1FF) pkt_q <= pkt_q + 9'd1;
      if (status != 8'd0 && err_q != 9'h1FF) err_q <= err_q + 9'd1;
    end
  end
  assign pkt_cnt = pkt_q;
  assign err_cnt = err_q;
`else
  assign pkt_cnt = 9'd0;
  assign err_cnt = 9'd0;
`endif
endmodule

// File: doc/pkt_responder.md
# pkt_responder

Packet-sink block sitting at the DUT end of the stimulus path that the testbench BFM drives. It accepts length-prefixed byte packets over a valid/ready stream, checks framing against `in_last`, and accumulates an 8-bit modular sum of the payload. For every packet it queues one 16-bit response word (status + sum) in an internal FIFO. The BFM monitor drains that FIFO over a second valid/ready port.

## Interface

Parameters:
- `RESP_DEPTH`, 4: response FIFO depth, power of two, at least 2.

Ports (one clock `clk`; reset `rst_n` is asynchronous and active-low):
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  input byte valid.
- `in_ready`  output  1  block can accept a byte.
- `in_data`  input  8  header or payload byte.
- `in_last`  input  1  sender marks the final byte of a packet.
- `resp_valid`  output  1  response word available.
- `resp_ready`  input  1  monitor accepts the response.
- `resp_data`  output  16  `{status[7:0], sum[7:0]}`.
- `pkt_cnt`  output  9  packets completed; saturates at 511.
- `err_cnt`  output  9  packets with status ≠ 0; saturates at 511.

## Operation

- A byte transfers when `in_valid && in_ready`. A response transfers when `resp_valid && resp_ready`.
- Packet format:
  - Byte 0 is the header, length L. A value of 0 means L = 256.
  - The header is followed by L payload bytes. `sum` is the mod-256 sum of the payload bytes.
- FSM states: `HDR`, `PAY`, `DRAIN`, `DONE`.
- `HDR`:
  - Accepting the header loads `remaining` (9 bits) with L and clears `sum`. Next state is `PAY`.
  - If the header byte itself carries `in_last`: status 0x01, sum 0, next state `DONE`.
- `PAY`: each accepted byte adds to `sum` and decrements `remaining`.
  - `in_last` on the byte that brings `remaining` to 0: status 0x00, next state `DONE`.
  - `in_last` with `remaining` still nonzero after the byte: status 0x01 (short), next state `DONE`.
  - `remaining` reaches 0 without `in_last`: status 0x02 (long), next state `DRAIN`.
- `DRAIN`: accepts and discards bytes, with no change to `sum`, until a byte with `in_last`, then goes to `DONE`.
- `DONE`:
  - `in_ready` = 0.
  - If the FIFO is not full, the block pushes `{status, sum}`, updates the counters, and returns to `HDR`.
  - If the FIFO is full, it holds in `DONE` and back-pressures the input.
- `in_ready` = 1 in `HDR`, `PAY` and `DRAIN`, and is a registered-state decode only. It never depends on `in_valid`.
- Response FIFO:
  - `resp_valid` = !empty. `resp_data` is the head entry, stable while `resp_valid && !resp_ready`.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - A push while full cannot occur, because `DONE` stalls.
  - Pointers are log2(`RESP_DEPTH`)+1 bits and wrap naturally.
- Counters:
  - `pkt_cnt` increments on every push.
  - `err_cnt` increments on a push with status ≠ 0.
  - Both saturate at 511 and never wrap.

## Timing

- Reset values while `rst_n` is low: state `HDR`, `in_ready` = 1, `resp_valid` = 0, `resp_data` = 0, `pkt_cnt` = 0, `err_cnt` = 0, FIFO empty.
- Reset mid-packet discards the partial packet and all queued responses.
- Latency: last byte accepted in cycle N, `DONE` in cycle N+1, push at the end of N+1, `resp_valid` high in cycle N+2.
- Throughput: one idle input cycle (`DONE`) per packet, so a packet of L payload bytes occupies L+2 cycles minimum.
- The monitor may hold `resp_ready` low indefinitely. Input stalls once `RESP_DEPTH` responses are pending.

## Configuration

- `PKT_RESP_STATS_EN` defined: `pkt_cnt` and `err_cnt` are implemented as specified.
- Not defined: the counter registers are not built and both ports are tied to 0. All other behaviour is identical.

## Test plan

- Header 0x03 followed by payload 0x10, 0x20, 0x30, with `in_last` on 0x30 → `resp_data` = 0x0060, `resp_valid` in cycle N+2, `pkt_cnt` = 1.
- Header 0x00 followed by 256 bytes of 0xFF, `in_last` on the last → status 0x00, sum 0x00, `resp_data` = 0x0000.
- Header 0x04 followed by 0x01, 0x02, with `in_last` on 0x02 → `resp_data` = 0x0103, `err_cnt` = 1. Header 0x02 followed by 0x05, 0x06, 0x07, 0x08, with `in_last` on 0x08 → `resp_data` = 0x020B, bytes 0x07 and 0x08 discarded.
- `resp_ready` held 0, 6 back-to-back 1-byte packets, `RESP_DEPTH` = 4 → the 5th packet stalls in `DONE` with `in_ready` = 0. Releasing `resp_ready` drains the responses in order and the 5th and 6th packets complete.
- `rst_n` asserted for 1 cycle mid-payload with 2 responses queued → `resp_valid` = 0 and counters 0 immediately. The next header is accepted normally.
- Run 256 random-length good packets, then 256 short packets, with `PKT_RESP_STATS_EN` defined → `pkt_cnt` = 511 and `err_cnt` = 256 (`pkt_cnt` saturated). Without the macro, both ports stay 0.
